// File: rtl/stream_min_max.sv
// stream_min_max: streaming signed min/max/count reduction over one frame of samples.
// Latency: out_valid rises on the edge that accepts the in_last sample.
// Backpressure: in_ready is low while a result waits, so there is always a one-cycle bubble between frames.
//
// Ports:
//   clk, rst                           clock; synchronous active-low reset
//   in_valid/in_ready/in_data/in_last  sample stream in; in_last closes the frame
//   out_valid/out_ready                result handshake
//   out_min/out_max/out_count          signed min, signed max and saturating sample count of the frame

// comparator_lt: lt = (a < b) for two's-complement a and b, combinational.
// Both operands are sign-extended by one bit before subtracting, so the difference
// cannot overflow. Its sign bit is therefore a correct signed less-than, even for the extremes.
module comparator_lt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  logic [N:0] a_x;
  logic [N:0] b_x;

  assign a_x = {a[N-1], a};
  assign b_x = {b[N-1], b};
  assign lt  = 1'((a_x - b_x) >> N);

endmodule

module stream_min_max #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_min,
  output logic [N-1:0]  out_max,
  output logic [CW-1:0] out_count
);

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  min_q;
  logic [N-1:0]  min_nxt;
  logic [N-1:0]  max_q;
  logic [N-1:0]  max_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;

  logic acc;
  logic take;
  logic new_min;
  logic new_max;

  // sample < current min
  comparator_lt #(.N(N)) u_lt_min (
    .a  (in_data),
    .b  (min_q),
    .lt (new_min)
  );

  // current max < sample
  comparator_lt #(.N(N)) u_lt_max (
    .a  (max_q),
    .b  (in_data),
    .lt (new_max)
  );

  assign in_ready  = (state != S_HOLD);
  assign out_valid = (state == S_HOLD);
  assign acc       = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = cnt_q;

  always_comb begin
    state_nxt = state;
    min_nxt   = min_q;
    max_nxt   = max_q;
    cnt_nxt   = cnt_q;

    unique case (state)
      S_FIRST: begin
        if (acc) begin
          // First sample seeds both extremes. This also overwrites the previous frame's result.
          min_nxt   = in_data;
          max_nxt   = in_data;
          cnt_nxt   = CW'(1);
          state_nxt = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (acc) begin
          // Strict compares, so a sample equal to the current extreme leaves it untouched.
          if (new_min) min_nxt = in_data;
          if (new_max) max_nxt = in_data;
          if (cnt_q != {CW{1'b1}}) cnt_nxt = cnt_q + CW'(1);
          if (in_last) state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // The result registers stay frozen here. They remain readable after the
        // take until the next frame's first sample replaces them.
        if (take) state_nxt = S_FIRST;
      end
      default: state_nxt = S_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FIRST;
      min_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      min_q <= min_nxt;
      max_q <= max_nxt;
      cnt_q <= cnt_nxt;
    end
  end

endmodule
